// File: rtl/gated_reg_bist.sv
// On-chip stimulus driver and response checker for an enable-gated register.
// Define GATED_BIST_STOP_ON_FAIL_EN to end a run at the first mismatching vector.
module gated_reg_bist #(
   parameter int         WIDTH       = 8,
   parameter int         NUM_VECTORS = 16,
   parameter logic [7:0] SEED        = 8'hA5
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   output logic [WIDTH-1:0] D_IN,
   output logic             EN,
   input  logic [WIDTH-1:0] D_OUT,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [7:0]       ERR_COUNT,
   output logic [7:0]       FAIL_IDX
);

   // Right-shift Galois masks; maximal-length for the listed widths,
   // other widths fall back to a fixed mask that keeps the top bit fed.
   function automatic logic [WIDTH-1:0] tap_mask();
      logic [WIDTH-1:0] m;
      m          = '0;
      m[WIDTH-1] = 1'b1;
      m[0]       = 1'b1;
      case (WIDTH)
         4:       m = WIDTH'(64'hC);
         5:       m = WIDTH'(64'h14);
         6:       m = WIDTH'(64'h30);
         7:       m = WIDTH'(64'h60);
         8:       m = WIDTH'(64'hB8);
         16:      m = WIDTH'(64'hB400);
         32:      m = WIDTH'(64'h8020_0003);
         default: ;
      endcase
      return m;
   endfunction

   localparam logic [WIDTH-1:0] TAPS     = tap_mask();
   localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
   localparam logic [WIDTH-1:0] SEED_INI = (SEED_W == '0) ? WIDTH'(1) : SEED_W;
   localparam logic [7:0]       LAST_IDX = 8'(NUM_VECTORS - 1);

   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
      return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_DRIVE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] exp_val;
   logic [7:0]       idx;
   logic [7:0]       err_cnt;
   logic [7:0]       fail_idx_q;
   logic             mismatch;
   logic             last_vec;

   assign mismatch  = (D_OUT != exp_val);
   assign last_vec  = (idx == LAST_IDX);
   assign ERR_COUNT = err_cnt;
   assign FAIL_IDX  = fail_idx_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // D_IN stays on the current vector through CHECK; EN drops so the DUT holds.
   always_comb begin
      state_nxt = state;
      D_IN      = '0;
      EN        = 1'b0;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      PASS      = 1'b0;
      case (state)
         S_IDLE: begin
            if (START) state_nxt = S_INIT;
         end
         S_INIT: begin
            EN        = 1'b1;
            BUSY      = 1'b1;
            state_nxt = S_DRIVE;
         end
         S_DRIVE: begin
            D_IN      = lfsr;
            EN        = lfsr[WIDTH-1];
            BUSY      = 1'b1;
            state_nxt = S_CHECK;
         end
         S_CHECK: begin
            D_IN = lfsr;
            BUSY = 1'b1;
`ifdef GATED_BIST_STOP_ON_FAIL_EN
            if (mismatch || last_vec) state_nxt = S_DONE;
            else                      state_nxt = S_DRIVE;
`else
            if (last_vec) state_nxt = S_DONE;
            else          state_nxt = S_DRIVE;
`endif
         end
         S_DONE: begin
            DONE = 1'b1;
            PASS = (err_cnt == 8'd0);
            if (START) state_nxt = S_INIT;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // The LFSR is reseeded on every INIT so each run replays the same vectors.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         lfsr       <= SEED_INI;
         exp_val    <= '0;
         idx        <= 8'd0;
         err_cnt    <= 8'd0;
         fail_idx_q <= 8'hFF;
      end else begin
         case (state)
            S_INIT: begin
               lfsr       <= SEED_INI;
               exp_val    <= '0;
               idx        <= 8'd0;
               err_cnt    <= 8'd0;
               fail_idx_q <= 8'hFF;
            end
            S_DRIVE: begin
               if (lfsr[WIDTH-1]) exp_val <= lfsr;
            end
            S_CHECK: begin
               if (mismatch) begin
                  err_cnt <= sat_inc(err_cnt);
                  if (fail_idx_q == 8'hFF) fail_idx_q <= idx;
               end
               lfsr <= lfsr_next(lfsr);
               idx  <= idx + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gated_reg_bist.sv
// Directed bench for gated_reg_bist driving a behavioural enable register
// with selectable faults: 0 correct, 1 output stuck at 0, 2 ignores EN.
module tb_gated_reg_bist;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] d_in;
   logic       en;
   logic [7:0] d_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [7:0] fail_idx;

   int         mode = 0;
   logic [7:0] q = 8'h00;
   int         errors = 0;
   int         checks = 0;
   int         cyc;

   // Hand-derived Galois sequence from seed A5 with mask B8, one entry per vector.
   logic [7:0] vec_tab [16] = '{8'hA5, 8'hEA, 8'h75, 8'h82, 8'h41, 8'h98, 8'h4C, 8'h26,
                                8'h13, 8'hB1, 8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07};

   gated_reg_bist #(.WIDTH(8), .NUM_VECTORS(16), .SEED(8'hA5)) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .START     (start),
      .D_IN      (d_in),
      .EN        (en),
      .D_OUT     (d_out),
      .BUSY      (busy),
      .DONE      (done),
      .PASS      (pass),
      .ERR_COUNT (err_count),
      .FAIL_IDX  (fail_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mode == 2 || en) q <= d_in;
   end
   assign d_out = (mode == 1) ? 8'h00 : q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_err"}, 32'(err_count), 0);
      chk({tag, "_fidx"}, 32'(fail_idx), 32'hFF);
      chk({tag, "_en"}, 32'(en), 0);
      chk({tag, "_din"}, 32'(d_in), 0);
   endtask

   // Entered one cycle after START was sampled (INIT is cycle 1); returns the
   // cycle number in which DONE is first seen, or the budget on timeout.
   task automatic wait_done(input int repulse_at, input bit check_vec, output int c);
      int busy_gaps;
      int k;
      busy_gaps = 0;
      c = 1;
      while (!done && c < 200) begin
         if (!busy) busy_gaps++;
         if (check_vec) begin
            if (c == 1) begin
               chk("init_en", 32'(en), 1);
               chk("init_din", 32'(d_in), 0);
            end else if (c % 2 == 0) begin
               k = (c - 2) / 2;
               chk("drive_din", 32'(d_in), 32'(vec_tab[k]));
               chk("drive_en", 32'(en), 32'(vec_tab[k][7]));
            end else begin
               k = (c - 3) / 2;
               chk("check_en", 32'(en), 0);
               chk("check_din", 32'(d_in), 32'(vec_tab[k]));
            end
         end
         start = (c == repulse_at);
         tick();
         c++;
      end
      start = 1'b0;
      chk("busy_during_run", 32'(busy_gaps), 0);
      chk("busy_at_done", 32'(busy), 0);
   endtask

   task automatic run(input int repulse_at, input bit check_vec, output int c);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(repulse_at, check_vec, c);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();
      chk("idle_no_start", 32'(busy), 0);

      // Correct DUT: full run, vectors and timing.
      mode = 0;
      run(0, 1'b1, cyc);
      chk("t1_latency", 32'(cyc), 34);
      chk("t1_pass", 32'(pass), 1);
      chk("t1_err", 32'(err_count), 0);
      chk("t1_fidx", 32'(fail_idx), 32'hFF);
      chk("t1_en", 32'(en), 0);
      repeat (3) tick();
      chk("t1_done_held", 32'(done), 1);

      // Stuck-at-0 output: every expected value is non-zero.
      mode = 1;
      run(0, 1'b0, cyc);
`ifdef GATED_BIST_STOP_ON_FAIL_EN
      chk("t2_latency", 32'(cyc), 4);
      chk("t2_err", 32'(err_count), 1);
`else
      chk("t2_latency", 32'(cyc), 34);
      chk("t2_err", 32'(err_count), 16);
`endif
      chk("t2_pass", 32'(pass), 0);
      chk("t2_fidx", 32'(fail_idx), 0);

      // DUT ignores EN: vector 2 (75, EN=0) is the first to differ from EA.
      mode = 2;
      run(0, 1'b0, cyc);
`ifdef GATED_BIST_STOP_ON_FAIL_EN
      chk("t3_latency", 32'(cyc), 8);
      chk("t3_err", 32'(err_count), 1);
`else
      chk("t3_latency", 32'(cyc), 34);
      chk("t3_err", 32'(err_count), 10);
`endif
      chk("t3_pass", 32'(pass), 0);
      chk("t3_fidx", 32'(fail_idx), 2);

      // Reset mid-run while errors are accumulating.
      mode = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      rst_n = 1'b0;
      tick();
      chk_reset_outputs("midrun_reset");
      rst_n = 1'b1;
      tick();
      chk("after_reset_idle", 32'(busy), 0);
      mode = 0;
      run(0, 1'b0, cyc);
      chk("t4_latency", 32'(cyc), 34);
      chk("t4_pass", 32'(pass), 1);
      chk("t4_err", 32'(err_count), 0);
      chk("t4_fidx", 32'(fail_idx), 32'hFF);

      // START re-pulsed while busy is ignored.
      run(5, 1'b0, cyc);
      chk("t5_latency", 32'(cyc), 34);
      chk("t5_pass", 32'(pass), 1);

      // START held in DONE restarts straight into INIT.
      start = 1'b1;
      tick();
      chk("t5_restart_done", 32'(done), 0);
      chk("t5_restart_busy", 32'(busy), 1);
      chk("t5_restart_en", 32'(en), 1);
      chk("t5_restart_din", 32'(d_in), 0);
      start = 1'b0;
      wait_done(0, 1'b1, cyc);
      chk("t5_rerun_latency", 32'(cyc), 34);
      chk("t5_rerun_pass", 32'(pass), 1);
      chk("t5_rerun_fidx", 32'(fail_idx), 32'hFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
